// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences the PC, fetches over a req/ack handshake and presents
// decoded fields under valid/ready. Optional illegal-opcode trap via FETCH_ILLEGAL_TRAP_EN.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 8,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [3:0]             o_opcode,
  output logic [3:0]             o_rd,
  output logic [3:0]             o_rs1,
  output logic [3:0]             o_rs2,
  output logic [PC_WIDTH-1:0]    o_pc_out,
  input  logic                   i_redirect_valid,
  input  logic [PC_WIDTH-1:0]    i_redirect_pc,
  output logic                   o_illegal
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam logic [1:0] StTrap = 2'd3;
`endif

  logic [1:0]             r_state, w_state;
  logic [PC_WIDTH-1:0]    r_pc, w_pc;
  logic [PC_WIDTH-1:0]    r_pc_out, w_pc_out;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr;
  logic                   r_valid, w_valid;
  logic                   r_req, w_req;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic                   r_illegal, w_illegal;
  logic                   w_bad_opcode;

  assign w_bad_opcode = i_imem_rdata[INSTR_WIDTH-1 -: 4] > 4'd3;
`endif

  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_pc_out = r_pc_out;
    w_instr  = r_instr;
    w_valid  = r_valid;
    w_req    = r_req;
`ifdef FETCH_ILLEGAL_TRAP_EN
    w_illegal = r_illegal;
`endif
    case (r_state)
      StIdle: begin
        w_state = StReq;
        w_req   = 1'b1;
      end
      StReq: begin
        // Redirect wins over a same-cycle ack: the returned word is dropped.
        if (i_redirect_valid) begin
          w_pc = i_redirect_pc;
        end else if (i_imem_ack) begin
          w_instr  = i_imem_rdata;
          w_pc_out = r_pc;
          w_pc     = r_pc + PC_WIDTH'(1);
          w_req    = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (w_bad_opcode) begin
            w_state   = StTrap;
            w_illegal = 1'b1;
          end else begin
            w_state = StHold;
            w_valid = 1'b1;
          end
`else
          w_state = StHold;
          w_valid = 1'b1;
`endif
        end
      end
      StHold: begin
        if (i_redirect_valid) begin
          w_pc    = i_redirect_pc;
          w_valid = 1'b0;
          w_req   = 1'b1;
          w_state = StReq;
        end else if (i_instr_ready) begin
          w_valid = 1'b0;
          w_req   = 1'b1;
          w_state = StReq;
        end
      end
`ifdef FETCH_ILLEGAL_TRAP_EN
      StTrap: begin
        if (i_redirect_valid) begin
          w_pc      = i_redirect_pc;
          w_illegal = 1'b0;
          w_req     = 1'b1;
          w_state   = StReq;
        end
      end
`endif
      default: begin
        w_state = StIdle;
        w_req   = 1'b0;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_pc     <= RESET_PC;
      r_pc_out <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_req    <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_pc_out <= w_pc_out;
      r_instr  <= w_instr;
      r_valid  <= w_valid;
      r_req    <= w_req;
`ifdef FETCH_ILLEGAL_TRAP_EN
      r_illegal <= w_illegal;
`endif
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = r_valid;
  assign o_opcode      = r_instr[INSTR_WIDTH-1 -: 4];
  assign o_rd          = r_instr[11:8];
  assign o_rs1         = r_instr[7:4];
  assign o_rs2         = r_instr[3:0];
  assign o_pc_out      = r_pc_out;
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign o_illegal     = r_illegal;
`else
  assign o_illegal     = 1'b0;
`endif

endmodule
